// File: rtl/if_id_buffer.sv
// if_id_buffer: two-entry fetch/decode skid buffer with registered in_ready; pre-decode enabled by IF_ID_PREDECODE_EN
module if_id_buffer #(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [ILEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [ILEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [XLEN-1:0] out_imm,
  output logic            out_illegal
);
  localparam logic [ILEN-1:0] NOP = ILEN'(32'h0000_0013);
  logic            h_valid, s_valid, accept, consume;
  logic [XLEN-1:0] h_pc, s_pc;
  logic [ILEN-1:0] h_inst, s_inst;
  assign in_ready  = !s_valid;
  assign accept    = in_valid && in_ready && !flush;
  assign consume   = h_valid && out_ready;
  assign out_valid = h_valid;
  assign out_pc    = h_pc;
  assign out_inst  = h_inst;
  always_ff @(posedge clock) begin
    if (reset) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
      h_pc    <= '0;
      h_inst  <= NOP;
      s_pc    <= '0;
      s_inst  <= NOP;
    end else if (flush) begin
      h_valid <= 1'b0;
      s_valid <= 1'b0;
    end else if (consume && s_valid) begin
      h_pc    <= s_pc;
      h_inst  <= s_inst;
      s_valid <= 1'b0;
    end else if (consume || !h_valid) begin
      h_valid <= accept;
      if (accept) begin
        h_pc   <= in_pc;
        h_inst <= in_inst;
      end
    end else if (accept) begin
      s_valid <= 1'b1;
      s_pc    <= in_pc;
      s_inst  <= in_inst;
    end
  end
`ifdef IF_ID_PREDECODE_EN
  logic [6:0]      op;
  logic            is_i, is_s, is_b, is_u, is_j, is_r;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign op    = h_inst[6:0];
  assign is_i  = op inside {7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b1110011};
  assign is_s  = op == 7'b0100011;
  assign is_b  = op == 7'b1100011;
  assign is_u  = op inside {7'b0110111, 7'b0010111};
  assign is_j  = op == 7'b1101111;
  assign is_r  = op inside {7'b0110011, 7'b0111011};
  assign imm_i = {{(XLEN-12){h_inst[31]}}, h_inst[31:20]};
  assign imm_s = {{(XLEN-12){h_inst[31]}}, h_inst[31:25], h_inst[11:7]};
  assign imm_b = {{(XLEN-13){h_inst[31]}}, h_inst[31], h_inst[7], h_inst[30:25], h_inst[11:8], 1'b0};
  assign imm_u = {{(XLEN-32){h_inst[31]}}, h_inst[31:12], 12'b0};
  assign imm_j = {{(XLEN-21){h_inst[31]}}, h_inst[31], h_inst[19:12], h_inst[20], h_inst[30:21], 1'b0};
  always_comb begin
    out_rd      = h_inst[11:7];
    out_rs1     = h_inst[19:15];
    out_rs2     = h_inst[24:20];
    out_imm     = is_i ? imm_i : is_s ? imm_s : is_b ? imm_b : is_u ? imm_u : is_j ? imm_j : '0;
    out_illegal = h_valid && (h_inst[1:0] != 2'b11 || !(is_i || is_s || is_b || is_u || is_j || is_r));
  end
`else
  always_comb begin
    out_rd      = '0;
    out_rs1     = '0;
    out_rs2     = '0;
    out_imm     = '0;
    out_illegal = 1'b0;
  end
`endif
endmodule

// File: tb/tb_if_id_buffer.sv
// tb_if_id_buffer: directed plus random checks of if_id_buffer against a two-deep queue model
module tb_if_id_buffer;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
  logic [31:0] in_inst = '0;
  logic [63:0] in_pc = '0;
  logic        in_ready, out_valid, out_illegal;
  logic [31:0] out_inst;
  logic [63:0] out_pc, out_imm;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  if_id_buffer dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_inst(in_inst), .in_pc(in_pc),
    .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_rd(out_rd), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_imm(out_imm), .out_illegal(out_illegal)
  );
  always #5 clock = ~clock;
  typedef struct {logic [63:0] pc; logic [31:0] inst;} ent_t;
  ent_t        q[$];
  logic [63:0] last_pc = '0, fpc;
  logic [31:0] last_inst = 32'h13;
  bit          acc;
  int          checks = 0, errors = 0;
  logic [6:0]  ops[13] = '{7'h13, 7'h03, 7'h67, 7'h1b, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b, 7'h0b};
  function automatic logic [63:0] imm_ref(input logic [31:0] x);
    longint sg = x[31] ? -1 : 0;
    case (x[6:0])
      7'h13, 7'h03, 7'h67, 7'h1b, 7'h73: return sg * 4096 + x[31:20];
      7'h23: return sg * 4096 + 32 * x[31:25] + x[11:7];
      7'h63: return sg * 4096 + 2048 * x[7] + 32 * x[30:25] + 2 * x[11:8];
      7'h37, 7'h17: return sg * (64'sd1 << 32) + 4096 * x[31:12];
      7'h6f: return sg * (64'sd1 << 20) + 4096 * x[19:12] + 2048 * x[20] + 2 * x[30:21];
      default: return 64'd0;
    endcase
  endfunction
  function automatic bit legal(input logic [31:0] x);
    return x[1:0] == 2'b11 && x[6:0] inside {7'h13, 7'h03, 7'h67, 7'h1b, 7'h73, 7'h23, 7'h63,
                                             7'h37, 7'h17, 7'h6f, 7'h33, 7'h3b};
  endfunction
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
    chk("out_pc", out_pc, last_pc);
    chk("out_inst", 64'(out_inst), 64'(last_inst));
`ifdef IF_ID_PREDECODE_EN
    chk("out_rd", 64'(out_rd), 64'(last_inst[11:7]));
    chk("out_rs1", 64'(out_rs1), 64'(last_inst[19:15]));
    chk("out_rs2", 64'(out_rs2), 64'(last_inst[24:20]));
    chk("out_imm", out_imm, imm_ref(last_inst));
    chk("out_illegal", 64'(out_illegal), 64'(q.size() > 0 && !legal(last_inst)));
`else
    chk("out_rd", 64'(out_rd), 64'd0);
    chk("out_rs1", 64'(out_rs1), 64'd0);
    chk("out_rs2", 64'(out_rs2), 64'd0);
    chk("out_imm", out_imm, 64'd0);
    chk("out_illegal", 64'(out_illegal), 64'd0);
`endif
  endtask
  task automatic step(input logic v, input logic [31:0] i, input logic [63:0] p,
                      input logic ordy, input logic fl);
    bit con;
    ent_t e;
    in_valid = v; in_inst = i; in_pc = p; out_ready = ordy; flush = fl;
    acc = v && q.size() < 2 && !fl && !reset;
    con = q.size() > 0 && ordy;
    @(posedge clock);
    if (reset) begin
      q.delete();
      last_pc = '0;
      last_inst = 32'h13;
    end else if (fl) q.delete();
    else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        e.pc = p;
        e.inst = i;
        q.push_back(e);
      end
    end
    if (q.size() > 0) begin
      last_pc = q[0].pc;
      last_inst = q[0].inst;
    end
    #1;
    check_all();
  endtask
  task automatic fetch(input logic [31:0] i, input logic ordy);
    step(1'b1, i, fpc, ordy, 1'b0);
    if (acc) fpc += 4;
  endtask
  initial begin
    #1;
    step(1'b1, 32'h00100093, 64'h8000_0000, 1'b1, 1'b0);
    step(1'b1, 32'h00100093, 64'h8000_0000, 1'b1, 1'b0);
    reset = 1'b0;
    fpc = 64'h8000_0000;
    fetch(32'h00100093, 1'b1);
    fetch(32'h00200113, 1'b1);
    fetch(32'h002081b3, 1'b1);
    for (int k = 0; k < 3; k++) fetch(32'h00000013 | (32'(k + 4) << 7), 1'b0);
    for (int k = 0; k < 4; k++) fetch(32'h00000013 | (32'(k + 8) << 7), 1'b1);
    fetch(32'h00000013, 1'b0);
    fetch(32'h00000013, 1'b0);
    step(1'b1, 32'h00000013, 64'h8000_0010, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 64'h8000_0100, 1'b1, 1'b0);
    step(1'b1, 32'hfe000ee3, 64'h8000_0104, 1'b1, 1'b0);
    step(1'b1, 32'h800000ef, 64'h8000_0108, 1'b1, 1'b0);
    step(1'b1, 32'h00000000, 64'h8000_010c, 1'b1, 1'b0);
    step(1'b1, 32'h00500293, 64'h8000_0110, 1'b0, 1'b1);
    step(1'b1, 32'h00000013, 64'h8000_0200, 1'b1, 1'b0);
    step(1'b1, 32'h00600313, 64'h8000_0204, 1'b0, 1'b0);
    step(1'b1, 32'h00700393, 64'h8000_0208, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 32'h00800413, 64'h8000_020c, 1'b1, 1'b0);
    reset = 1'b0;
    fpc = 64'h8000_1000;
    for (int k = 0; k < 400; k++) begin
      logic [31:0] r;
      logic        fl;
      r = $urandom();
      fl = $urandom_range(0, 15) == 0;
      if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
      step($urandom_range(0, 3) != 0, r, fpc, $urandom_range(0, 2) != 0, fl);
      if (fl) fpc = {32'd0, $urandom()} & ~64'd3;
      else if (acc) fpc += 4;
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
